// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial add/subtract controller.
// Contents: FSM state encoding constants, state enum, WIDTH legality check.
package serial_adder_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_RUN  = ST_RUN,
      S_DONE = ST_DONE
   } state_t;

   localparam int unsigned WIDTH_MIN = 1;
   localparam int unsigned WIDTH_MAX = 64;

   // True when an operand width is supported by the controller.
   function automatic bit width_legal(input int unsigned w);
      return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
   endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell shared by the serial datapath.
// Ports: a, b, cin in; sum, cout out (purely combinational).
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller: one full_adder time-shared over WIDTH
// bits, LSB first, one bit per clock, with valid/ready on both sides.
// Ports:
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_valid/o_ready        operand handshake (o_ready high only in IDLE)
//   i_a, i_b, i_sub        operands and op select (1 = A-B)
//   o_valid/i_ready        result handshake (result held until taken)
//   o_sum, o_carry         result and carry out of MSB (sub: 1 = no borrow)
//   o_overflow             signed overflow
//   o_busy                 high while bits are being processed
module serial_adder_ctrl
   import serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_sub,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_carry,
   output logic             o_overflow,
   output logic             o_busy
);

   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   if (!width_legal(WIDTH)) begin : g_width_chk
      $error("serial_adder_ctrl: WIDTH must be within 1..64");
   end

   state_t             state_q;
   state_t             state_d;
   logic               accept_c;
   logic               step_c;
   logic               last_c;

   logic [WIDTH-1:0]   sh_a;
   logic [WIDTH-1:0]   sh_b;
   logic [WIDTH-1:0]   sum_q;
   logic [CNT_W-1:0]   cnt;
   logic               carry_q;
   logic               ready_q;
   logic               valid_q;
   logic               busy_q;
   logic               carry_out_q;
   logic               ovf_q;

   logic               fa_sum;
   logic               fa_cout;

   // Shared adder cell fed from the operand LSBs and the running carry.
   full_adder u_fa (
      .a    (sh_a[0]),
      .b    (sh_b[0]),
      .cin  (carry_q),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   // State register; handshake/status flags are registered from the next state.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ready_q <= (state_d == S_IDLE);
         valid_q <= (state_d == S_DONE);
         busy_q  <= (state_d == S_RUN);
      end
   end

   // Next-state decode and datapath strobes.
   always_comb begin
      state_d  = state_q;
      accept_c = 1'b0;
      step_c   = 1'b0;
      last_c   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (i_valid) begin
               accept_c = 1'b1;
               state_d  = S_RUN;
            end
         end
         S_RUN: begin
            step_c = 1'b1;
            if (cnt == LAST_BIT) begin
               last_c  = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (i_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Operand shifters, carry FF, bit counter and result register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sh_a        <= '0;
         sh_b        <= '0;
         sum_q       <= '0;
         cnt         <= '0;
         carry_q     <= 1'b0;
         carry_out_q <= 1'b0;
         ovf_q       <= 1'b0;
      end else if (accept_c) begin
         // Subtraction as A + ~B + 1: invert B and seed the carry with 1.
         sh_a    <= i_a;
         sh_b    <= i_sub ? ~i_b : i_b;
         carry_q <= i_sub;
         cnt     <= '0;
      end else if (step_c) begin
         sum_q   <= (sum_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
         sh_a    <= sh_a >> 1;
         sh_b    <= sh_b >> 1;
         carry_q <= fa_cout;
         cnt     <= cnt + CNT_W'(1);
         if (last_c) begin
            // carry_q here is the carry into the MSB.
            carry_out_q <= fa_cout;
            ovf_q       <= carry_q ^ fa_cout;
         end
      end
   end

   assign o_ready    = ready_q;
   assign o_valid    = valid_q;
   assign o_busy     = busy_q;
   assign o_sum      = sum_q;
   assign o_carry    = carry_out_q;
   assign o_overflow = ovf_q;

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial add/subtract controller that time-shares one full_adder cell over a WIDTH-bit operand pair, one bit per clock, LSB first. It owns the operand shift registers, the carry flip-flop, the bit counter and a valid/ready handshake on both sides. It is the area-minimal arithmetic unit for SISD paths where latency is cheap and gates are not.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..64
CNT_W, $clog2(WIDTH)+1, bit-counter width (derived; not overridden)

Ports:
i_clk  input  1  rising-edge clock
i_rst  input  1  synchronous active-high reset
i_valid  input  1  operand request valid
o_ready  output  1  block can accept operands (high only in IDLE)
i_a  input  WIDTH  operand A
i_b  input  WIDTH  operand B
i_sub  input  1  0 = A+B, 1 = A-B (two's complement)
o_valid  output  1  result valid, held until taken
i_ready  input  1  consumer accepts result
o_sum  output  WIDTH  result
o_carry  output  1  carry out of MSB (for sub: 1 = no borrow)
o_overflow  output  1  signed overflow (carry into MSB XOR carry out of MSB)
o_busy  output  1  high in RUN

Behaviour:
- Clock i_clk; reset i_rst synchronous, active-high, sampled on the rising edge; all state cleared, no asynchronous paths.
- Reset values: state=IDLE, o_ready=1, o_valid=0, o_busy=0, o_sum=0, o_carry=0, o_overflow=0, counter=0, carry FF=0.
- States IDLE, RUN, DONE (binary encoded).
- IDLE: o_ready=1. On an edge with i_valid=1: latch A into shift reg A, latch (i_sub ? ~i_b : i_b) into shift reg B, carry FF <= i_sub, counter <= 0, go RUN. i_a/i_b/i_sub are sampled only on that edge.
- RUN: o_busy=1, o_ready=0. full_adder inputs are A[0], B[0] and the carry FF. Each edge: result reg shifts right with the sum bit entering the MSB; A and B shift right; carry FF <= adder carry; counter += 1. When counter==WIDTH-1 on that edge: o_carry <= adder carry, o_overflow <= carry FF XOR adder carry (carry into and out of the MSB), go DONE.
- Latency: operands accepted at edge k; o_valid is high from edge k+WIDTH. WIDTH=1 gives a single RUN cycle.
- DONE: o_valid=1; o_sum, o_carry and o_overflow are stable. On an edge with i_ready=1, go IDLE and clear o_valid. No new accept happens on that same edge, so there is one IDLE cycle minimum between jobs.
- Backpressure: DONE holds indefinitely while i_ready=0, with the outputs unchanged.
- i_valid while not in IDLE is ignored; the requester must hold it until o_ready.
- i_ready outside DONE is ignored.
- Reset mid-RUN or mid-DONE aborts the job and returns to reset values on the next edge; the result is discarded.
- o_sum changes only during RUN. Between jobs it retains the last result.

Decomposition:
- Package serial_adder_pkg holds the state encoding constants (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2) and the WIDTH legality check function.
- One sub-module: the existing full_adder, instantiated once, fed from the shift-register LSBs and the carry FF.
- FSM, counter and shift registers stay inline in serial_adder_ctrl.

Test Plan:
- WIDTH=8, A=0x0F, B=0x01, sub=0 -> o_valid exactly 8 cycles after accept; o_sum=0x10, carry=0, overflow=0.
- A=0xFF, B=0x01, add -> o_sum=0x00, carry=1, overflow=0. A=0x7F, B=0x01 -> o_sum=0x80, carry=0, overflow=1.
- A=0x05, B=0x07, sub=1 -> o_sum=0xFE, carry=0 (borrow). A=0x80, B=0x01, sub=1 -> o_sum=0x7F, overflow=1.
- Backpressure: hold i_ready=0 for 5 cycles in DONE -> o_valid and o_sum stable. Then i_ready=1 -> IDLE and o_ready=1 on the next cycle. A new i_valid held throughout RUN is accepted only in IDLE.
- Reset: assert i_rst at RUN bit 3 -> next edge state IDLE, o_valid=0, o_sum=0. A following job 0x12+0x34 -> 0x46.
- WIDTH=1: 1+1 -> o_sum=0, carry=1, o_valid 1 cycle after accept. Back-to-back random operands vs a reference model, 1000 jobs, random i_ready stalls.
